core_fetch_redirect: RTL and testbench
======================================

CORE_FETCH_REDIRECT -- requirements
Module: core_fetch_redirect

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset SHALL be this value.
REQ-002 CLK  in  1  clock; all state SHALL update on the rising edge.
REQ-003 NRST  in  1  reset, synchronous, active-low.
REQ-004 TAKE_BRANCH  in  1  registered branch decision from the branch-condition unit; a high level for one cycle is one redirect.
REQ-005 BRANCH_TARGET  in  32  redirect address; SHALL be sampled only in cycles where TAKE_BRANCH=1.
REQ-006 IMEM_REQ  out  1  instruction-memory request.
REQ-007 IMEM_ADDR  out  32  fetch address; valid while IMEM_REQ=1.
REQ-008 IMEM_ACK  in  1  memory completion; IMEM_RDATA is valid in the same cycle.
REQ-009 IMEM_RDATA  in  32  fetched instruction word.
REQ-010 IF_VALID  out  1  IF_INSTR and IF_PC hold a live instruction for decode.
REQ-011 IF_INSTR  out  32  fetched instruction.
REQ-012 IF_PC  out  32  address of IF_INSTR.
REQ-013 ID_READY  in  1  decode accepts the instruction this cycle when IF_VALID=1.
REQ-014 FLUSH  out  1  one-cycle kill pulse to the younger pipeline stages.
REQ-015 ADDR_MISALIGN  out  1  one-cycle pulse when an accepted target has bits [1:0] != 0.

Function
REQ-016 The block SHALL hold an internal fetch PC and use three states: FETCH, WAIT_ID, DRAIN.
REQ-017 IMEM handshake: once IMEM_REQ rises, IMEM_REQ and IMEM_ADDR SHALL stay constant until the cycle IMEM_ACK=1; IMEM_ACK SHALL be ignored while IMEM_REQ=0.
REQ-018 FETCH: IMEM_REQ=1 and IMEM_ADDR=PC.
REQ-019 FETCH, ACK=1, TAKE_BRANCH=0: the block SHALL latch IF_INSTR<=IMEM_RDATA and IF_PC<=PC, set PC<=PC+4, set IF_VALID=1 next cycle, and move to WAIT_ID.
REQ-020 FETCH, ACK=1, TAKE_BRANCH=1: the block SHALL discard the data, set PC<=target, and remain in FETCH; the new request SHALL start the next cycle.
REQ-021 FETCH, ACK=0, TAKE_BRANCH=1: the block SHALL set PC<=target and move to DRAIN, with IMEM_ADDR still showing the old address.
REQ-022 DRAIN: IMEM_REQ=1 holding the old address; on ACK the data SHALL be discarded and the state SHALL return to FETCH using the redirected PC.
REQ-023 A TAKE_BRANCH received in DRAIN SHALL overwrite PC with the newest target.
REQ-024 WAIT_ID: IF_VALID=1 and IMEM_REQ=0.
REQ-025 WAIT_ID, ID_READY=1, TAKE_BRANCH=0: IF_VALID SHALL drop next cycle and the state SHALL move to FETCH.
REQ-026 WAIT_ID, TAKE_BRANCH=1: IF_VALID SHALL drop next cycle regardless of ID_READY, PC<=target, and the state SHALL move to FETCH.
REQ-027 Priority: TAKE_BRANCH SHALL take priority over ACK and ID_READY in every state.
REQ-028 Back-to-back redirects: each redirect SHALL be honoured, the last one wins, and the block SHALL emit one FLUSH per redirect cycle.
REQ-029 FLUSH SHALL be registered, high exactly in the cycle after each cycle with TAKE_BRANCH=1.
REQ-030 Target alignment: the target SHALL be stored with bits [1:0] forced to 0, and ADDR_MISALIGN SHALL be registered, pulsing in the same cycle as FLUSH.
REQ-031 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-032 Throughput: with ACK combinational in the REQ cycle and ID_READY=1, the block SHALL deliver one instruction every 2 cycles.

Reset
REQ-033 While NRST=0: IMEM_REQ=0, IF_VALID=0, FLUSH=0, ADDR_MISALIGN=0, IF_INSTR=0, IF_PC=0, PC=RESET_PC, state=FETCH.
REQ-034 In the first cycle with NRST=1, IMEM_REQ=1 and IMEM_ADDR=RESET_PC.
REQ-035 Reset mid-transaction SHALL abandon any outstanding request; instruction memory shares NRST, so no stale ACK follows.

Verification
REQ-036 Reset release, ACK in the same cycle, ID_READY=1 -> IMEM_ADDR sequence 0x0, 0x4, 0x8; IF_PC matches each address; IF_VALID high every other cycle.
REQ-037 ID_READY=0 for 3 cycles in WAIT_ID -> IF_VALID, IF_INSTR and IF_PC stable; IMEM_REQ=0 throughout.
REQ-038 TAKE_BRANCH=1 with target 0x100 while a request to 0x8 is waiting, ACK 2 cycles later -> IMEM_ADDR holds 0x8 until ACK, data discarded, next IMEM_ADDR=0x100, FLUSH pulses once.
REQ-039 TAKE_BRANCH to 0x200, then 0x300 on the next cycle, during DRAIN -> two FLUSH pulses, and the next fetch is 0x300.
REQ-040 Target 0x103 -> fetch address 0x100 and one ADDR_MISALIGN pulse.
REQ-041 Start from PC=0xFFFF_FFFC via a branch, fetch completes -> next IMEM_ADDR=0x0; NRST low during DRAIN -> IMEM_REQ=0 next cycle, then restart at RESET_PC.

Source files
------------

// File: rtl/core_fetch_redirect.sv
// ---------------------------------------------------------------------------
// core_fetch_redirect
//   Instruction-fetch stage with branch redirect. It holds the fetch PC and
//   issues one instruction-memory request at a time. It hands each fetched
//   word to decode and reacts to redirects from the branch unit. A redirect
//   that arrives while a request is still outstanding is parked: the old
//   request drains with its address held, its data is dropped, and fetch
//   then resumes at the newest target.
//
// Ports
//   CLK, NRST          clock (rising edge), synchronous active-low reset
//   TAKE_BRANCH        one-cycle redirect strobe
//   BRANCH_TARGET[31:0] redirect address, sampled only with TAKE_BRANCH
//   IMEM_REQ/IMEM_ADDR instruction-memory request and address
//   IMEM_ACK/IMEM_RDATA completion strobe and instruction word (same cycle)
//   IF_VALID/IF_INSTR/IF_PC  instruction presented to decode
//   ID_READY           decode accepts the presented instruction
//   FLUSH              registered kill pulse, one per redirect cycle
//   ADDR_MISALIGN      registered pulse for a target with bits [1:0] != 0
// ---------------------------------------------------------------------------
module core_fetch_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        TAKE_BRANCH,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        IF_VALID,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC,
    input  logic        ID_READY,
    output logic        FLUSH,
    output logic        ADDR_MISALIGN
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_WAIT_ID = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]  state_reg,      state_next;
    logic [31:0] pc_reg,         pc_next;
    logic [31:0] drain_addr_reg, drain_addr_next;
    logic        if_valid_reg,   if_valid_next;
    logic [31:0] if_instr_reg,   if_instr_next;
    logic [31:0] if_pc_reg,      if_pc_next;
    logic        flush_reg,      flush_next;
    logic        misalign_reg,   misalign_next;

    logic [31:0] target_aligned;

    assign target_aligned = {BRANCH_TARGET[31:2], 2'b00};

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        drain_addr_next = drain_addr_reg;
        if_valid_next   = if_valid_reg;
        if_instr_next   = if_instr_reg;
        if_pc_next      = if_pc_reg;
        flush_next      = TAKE_BRANCH;
        misalign_next   = TAKE_BRANCH && (BRANCH_TARGET[1:0] != 2'b00);

        case (state_reg)
            ST_FETCH: begin
                if (TAKE_BRANCH) begin
                    pc_next = target_aligned;
                    // Request still in flight: keep showing its address
                    // until memory completes it, then drop the data.
                    if (!IMEM_ACK) begin
                        drain_addr_next = pc_reg;
                        state_next      = ST_DRAIN;
                    end
                end else if (IMEM_ACK) begin
                    if_instr_next = IMEM_RDATA;
                    if_pc_next    = pc_reg;
                    pc_next       = pc_reg + 32'd4;   // wraps naturally at 2^32
                    if_valid_next = 1'b1;
                    state_next    = ST_WAIT_ID;
                end
            end
            ST_WAIT_ID: begin
                if (TAKE_BRANCH) begin
                    pc_next       = target_aligned;
                    if_valid_next = 1'b0;
                    state_next    = ST_FETCH;
                end else if (ID_READY) begin
                    if_valid_next = 1'b0;
                    state_next    = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // Newest redirect always wins; the drained data is ignored.
                if (TAKE_BRANCH) begin
                    pc_next = target_aligned;
                end
                if (IMEM_ACK) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next    = ST_FETCH;
                if_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_reg      <= ST_FETCH;
            pc_reg         <= RESET_PC;
            drain_addr_reg <= 32'd0;
            if_valid_reg   <= 1'b0;
            if_instr_reg   <= 32'd0;
            if_pc_reg      <= 32'd0;
            flush_reg      <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            drain_addr_reg <= drain_addr_next;
            if_valid_reg   <= if_valid_next;
            if_instr_reg   <= if_instr_next;
            if_pc_reg      <= if_pc_next;
            flush_reg      <= flush_next;
            misalign_reg   <= misalign_next;
        end
    end

    // The request is gated by NRST so that it is low during reset yet rises
    // in the very first cycle after release, without waiting for a register.
    assign IMEM_REQ      = NRST && (state_reg != ST_WAIT_ID);
    assign IMEM_ADDR     = (state_reg == ST_DRAIN) ? drain_addr_reg : pc_reg;
    assign IF_VALID      = if_valid_reg;
    assign IF_INSTR      = if_instr_reg;
    assign IF_PC         = if_pc_reg;
    assign FLUSH         = flush_reg;
    assign ADDR_MISALIGN = misalign_reg;

endmodule

// File: tb/tb_core_fetch_redirect.sv
// ---------------------------------------------------------------------------
// tb_core_fetch_redirect
//   Randomized bench for core_fetch_redirect. A transaction-level reference
//   model tracks what the fetch stage owes the outside world: the next fetch
//   address, whether an abandoned request is still waiting to complete, and
//   whether an instruction is being held for decode. Outputs are compared on
//   the falling edge; inputs are driven after the comparison.
// ---------------------------------------------------------------------------
module tb_core_fetch_redirect;

    logic        CLK = 1'b0;
    logic        NRST = 1'b0;
    logic        TAKE_BRANCH = 1'b0;
    logic [31:0] BRANCH_TARGET = 32'd0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IMEM_RDATA = 32'd0;
    logic        IF_VALID;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic        ID_READY = 1'b0;
    logic        FLUSH;
    logic        ADDR_MISALIGN;

    core_fetch_redirect #(.RESET_PC(32'h0000_0000)) dut (
        .CLK           (CLK),
        .NRST          (NRST),
        .TAKE_BRANCH   (TAKE_BRANCH),
        .BRANCH_TARGET (BRANCH_TARGET),
        .IMEM_REQ      (IMEM_REQ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_ACK      (IMEM_ACK),
        .IMEM_RDATA    (IMEM_RDATA),
        .IF_VALID      (IF_VALID),
        .IF_INSTR      (IF_INSTR),
        .IF_PC         (IF_PC),
        .ID_READY      (ID_READY),
        .FLUSH         (FLUSH),
        .ADDR_MISALIGN (ADDR_MISALIGN)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: what is owed to memory and to decode.
    logic [31:0] m_next_fetch;    // address of the next request to issue
    logic        m_abandoned;     // a request was redirected and must still complete
    logic [31:0] m_abandoned_addr;
    logic        m_holding;       // an instruction is parked for decode
    logic [31:0] m_hold_pc;
    logic [31:0] m_hold_instr;
    logic        m_flush;
    logic        m_mis;
    int          n_delivered = 0;

    task automatic model_reset();
        m_next_fetch     = 32'h0000_0000;
        m_abandoned      = 1'b0;
        m_abandoned_addr = 32'd0;
        m_holding        = 1'b0;
        m_hold_pc        = 32'd0;
        m_hold_instr     = 32'd0;
        m_flush          = 1'b0;
        m_mis            = 1'b0;
    endtask

    // Apply one clock edge's worth of inputs to the model.
    task automatic model_step();
        logic [31:0] tgt;
        tgt = BRANCH_TARGET & 32'hFFFF_FFFC;
        if (!NRST) begin
            model_reset();
        end else begin
            m_flush = TAKE_BRANCH;
            m_mis   = TAKE_BRANCH && (BRANCH_TARGET % 4 != 0);
            if (m_holding) begin
                if (TAKE_BRANCH || ID_READY) begin
                    if (!TAKE_BRANCH) begin
                        n_delivered++;
                        $display("deliver #%0d pc=%h instr=%h", n_delivered, m_hold_pc, m_hold_instr);
                    end
                    m_holding = 1'b0;
                end
                if (TAKE_BRANCH) m_next_fetch = tgt;
            end else if (m_abandoned) begin
                if (TAKE_BRANCH) m_next_fetch = tgt;
                if (IMEM_ACK) m_abandoned = 1'b0;
            end else begin
                // A live request to m_next_fetch is on the bus.
                if (TAKE_BRANCH) begin
                    if (!IMEM_ACK) begin
                        m_abandoned      = 1'b1;
                        m_abandoned_addr = m_next_fetch;
                    end
                    m_next_fetch = tgt;
                end else if (IMEM_ACK) begin
                    m_holding    = 1'b1;
                    m_hold_pc    = m_next_fetch;
                    m_hold_instr = IMEM_RDATA;
                    m_next_fetch = 32'(m_next_fetch + 64'd4);
                end
            end
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFC;
            1: return 32'h0000_0100;
            2: return 32'h0000_0103;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0300;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic exp_req;
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            if (c > 0) begin
                exp_req = NRST && !m_holding;
                check("imem_req", {31'd0, IMEM_REQ}, {31'd0, exp_req});
                if (exp_req)
                    check("imem_addr", IMEM_ADDR, m_abandoned ? m_abandoned_addr : m_next_fetch);
                check("if_valid", {31'd0, IF_VALID}, {31'd0, m_holding});
                if (m_holding) begin
                    check("if_pc", IF_PC, m_hold_pc);
                    check("if_instr", IF_INSTR, m_hold_instr);
                end
                check("flush", {31'd0, FLUSH}, {31'd0, m_flush});
                check("misalign", {31'd0, ADDR_MISALIGN}, {31'd0, m_mis});
            end

            // Drive the next cycle's inputs.
            IMEM_RDATA    = $urandom;
            BRANCH_TARGET = pick_target();
            if (c < 3) begin
                NRST = 1'b0; TAKE_BRANCH = 1'b0; ID_READY = 1'b1;
            end else if (c < 23) begin
                // Straight-line streaming: addresses 0,4,8,... every 2 cycles.
                NRST = 1'b1; TAKE_BRANCH = 1'b0; ID_READY = 1'b1;
            end else if (c < 45) begin
                // Decode back-pressure only.
                NRST = 1'b1; TAKE_BRANCH = 1'b0; ID_READY = ($urandom_range(0, 9) < 3);
            end else begin
                NRST        = ($urandom_range(0, 99) >= 2);
                TAKE_BRANCH = ($urandom_range(0, 9) < 2);
                ID_READY    = ($urandom_range(0, 1) == 1);
            end
            #1;
            // Memory only answers an active request.
            if (c < 45) IMEM_ACK = IMEM_REQ;
            else        IMEM_ACK = IMEM_REQ && ($urandom_range(0, 9) < 4);

            @(posedge CLK);
            model_step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
